alu_exec_unit: RTL and testbench

Parametrised execution core combining the general-purpose register file, operand/immediate select, ALU, flag register and an iterative multiplier behind a start/busy/done handshake. It replaces the fixed 16-bit, single-cycle regbank/mux/ALU/flag path in the CPU datapath. The global FSM issues one operation at a time and waits for `done`. Memory loads and the game controller write through a separate external write port.

---
 rtl/alu_exec_unit.sv | 236 +++++++++++++++++++++++
 tb/tb_alu_exec_unit.sv | 388 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_exec_unit.sv
`default_nettype none
// +------------------------------------------------------------------+
// | alu_exec_unit: register file, operand select, ALU, flags and      |
// | iterative shift-add multiplier behind a start/busy/done handshake |
// | Revision: 1.0                                                     |
// +------------------------------------------------------------------+
module alu_exec_unit #(
    parameter int WIDTH    = 16,
    parameter int NUM_REGS = 16,
    parameter int REG_AW   = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [3:0]        op,
    input  logic [REG_AW-1:0] rdst,
    input  logic [REG_AW-1:0] rsrc,
    input  logic [WIDTH-1:0]  imm,
    input  logic              imm_sel,
    input  logic              wb_en,
    input  logic              flag_en,
    input  logic              ext_wr_en,
    input  logic [REG_AW-1:0] ext_wr_addr,
    input  logic [WIDTH-1:0]  ext_wr_data,
    output logic [WIDTH-1:0]  rdst_val,
    output logic [WIDTH-1:0]  rsrc_val,
    output logic [WIDTH-1:0]  result,
    output logic [4:0]        flags,
    output logic              busy,
    output logic              done
);
    localparam int CW = $clog2(WIDTH);

    localparam logic [0:0]    c_st_idle   = 1'b0;
    localparam logic [0:0]    c_st_mul    = 1'b1;
    localparam logic [CW-1:0] c_last_iter = CW'(WIDTH - 1);

    localparam logic [3:0] c_op_add = 4'd0;
    localparam logic [3:0] c_op_sub = 4'd1;
    localparam logic [3:0] c_op_and = 4'd2;
    localparam logic [3:0] c_op_or  = 4'd3;
    localparam logic [3:0] c_op_xor = 4'd4;
    localparam logic [3:0] c_op_mov = 4'd5;
    localparam logic [3:0] c_op_cmp = 4'd6;
    localparam logic [3:0] c_op_lsh = 4'd7;
    localparam logic [3:0] c_op_mul = 4'd8;

    logic [WIDTH-1:0]   regs_q [NUM_REGS];
    logic [WIDTH-1:0]   regs_d [NUM_REGS];
    logic [0:0]         state_q, state_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic [4:0]         flags_q, flags_d;
    logic               done_q, done_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [2*WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [REG_AW-1:0]  mul_dst_q, mul_dst_d;
    logic               mul_wb_q, mul_wb_d;
    logic               mul_fen_q, mul_fen_d;

    logic [WIDTH-1:0]   w_op_a, w_op_b, w_neg_b, w_alu_res;
    logic [WIDTH:0]     w_sum, w_diff;
    logic [4:0]         w_alu_flags;
    logic               w_c, w_f, w_alu_wb, w_res_upd, w_flag_upd;
    logic [2*WIDTH-1:0] w_prod;
    logic               w_wb_fire;
    logic [REG_AW-1:0]  w_wb_addr;
    logic [WIDTH-1:0]   w_wb_data;

    // Out-of-range addresses match no entry and therefore read as zero.
    always_comb begin
        rdst_val = '0;
        rsrc_val = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (rdst == REG_AW'(i)) rdst_val = regs_q[i];
            if (rsrc == REG_AW'(i)) rsrc_val = regs_q[i];
        end
    end

    always_comb begin
        w_op_a     = rdst_val;
        w_op_b     = imm_sel ? imm : rsrc_val;
        w_sum      = {1'b0, w_op_a} + {1'b0, w_op_b};
        w_diff     = {1'b0, w_op_a} - {1'b0, w_op_b};
        w_neg_b    = -w_op_b;
        w_alu_res  = '0;
        w_c        = 1'b0;
        w_f        = 1'b0;
        w_alu_wb   = 1'b1;
        w_res_upd  = 1'b1;
        w_flag_upd = 1'b1;
        case (op)
            c_op_add: begin
                w_alu_res = w_sum[WIDTH-1:0];
                w_c       = w_sum[WIDTH];
                w_f       = (w_op_a[WIDTH-1] == w_op_b[WIDTH-1]) &&
                            (w_alu_res[WIDTH-1] != w_op_a[WIDTH-1]);
            end
            c_op_sub: begin
                w_alu_res = w_diff[WIDTH-1:0];
                w_c       = w_diff[WIDTH];
                w_f       = (w_op_a[WIDTH-1] != w_op_b[WIDTH-1]) &&
                            (w_alu_res[WIDTH-1] != w_op_a[WIDTH-1]);
            end
            c_op_and: w_alu_res = w_op_a & w_op_b;
            c_op_or:  w_alu_res = w_op_a | w_op_b;
            c_op_xor: w_alu_res = w_op_a ^ w_op_b;
            c_op_mov: begin
                w_alu_res  = w_op_b;
                w_flag_upd = 1'b0;
            end
            c_op_cmp: begin
                w_alu_res = w_diff[WIDTH-1:0];
                w_alu_wb  = 1'b0;
            end
            // Shift counts of WIDTH or more naturally produce zero.
            c_op_lsh: w_alu_res = w_op_b[WIDTH-1] ? (w_op_a >> w_neg_b) : (w_op_a << w_op_b);
            default: begin
                w_alu_wb   = 1'b0;
                w_res_upd  = 1'b0;
                w_flag_upd = 1'b0;
            end
        endcase
        if (op == c_op_cmp) begin
            w_alu_flags = {$signed(w_op_a) < $signed(w_op_b), w_op_a == w_op_b,
                           1'b0, w_diff[WIDTH], 1'b0};
        end else begin
            w_alu_flags = {w_alu_res[WIDTH-1], ~|w_alu_res, w_f, 1'b0, w_c};
        end
    end

    // Bit 0 of the multiplier is consumed in the start cycle, so the MUL
    // state needs only WIDTH-1 further iterations.
    always_comb begin
        state_d   = state_q;
        result_d  = result_q;
        flags_d   = flags_q;
        done_d    = 1'b0;
        acc_d     = acc_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        cnt_d     = cnt_q;
        mul_dst_d = mul_dst_q;
        mul_wb_d  = mul_wb_q;
        mul_fen_d = mul_fen_q;
        w_prod    = acc_q + (mplier_q[0] ? mcand_q : '0);
        w_wb_fire = 1'b0;
        w_wb_addr = rdst;
        w_wb_data = w_alu_res;
        case (state_q)
            c_st_idle: begin
                if (start) begin
                    if (op == c_op_mul) begin
                        state_d   = c_st_mul;
                        acc_d     = w_op_b[0] ? {{WIDTH{1'b0}}, w_op_a} : '0;
                        mcand_d   = {{(WIDTH-1){1'b0}}, w_op_a, 1'b0};
                        mplier_d  = w_op_b >> 1;
                        cnt_d     = CW'(1);
                        mul_dst_d = rdst;
                        mul_wb_d  = wb_en;
                        mul_fen_d = flag_en;
                    end else begin
                        done_d    = 1'b1;
                        w_wb_fire = w_alu_wb && wb_en;
                        if (w_res_upd) result_d = w_alu_res;
                        if (w_flag_upd && flag_en) flags_d = w_alu_flags;
                    end
                end
            end
            default: begin
                acc_d    = w_prod;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + CW'(1);
                if (cnt_q == c_last_iter) begin
                    state_d   = c_st_idle;
                    done_d    = 1'b1;
                    result_d  = w_prod[WIDTH-1:0];
                    w_wb_fire = mul_wb_q;
                    w_wb_addr = mul_dst_q;
                    w_wb_data = w_prod[WIDTH-1:0];
                    if (mul_fen_q) begin
                        flags_d = {w_prod[WIDTH-1], ~|w_prod[WIDTH-1:0], 1'b0, 1'b0,
                                   |w_prod[2*WIDTH-1:WIDTH]};
                    end
                end
            end
        endcase
    end

    // ALU writeback is applied after the external write so it wins on a collision.
    always_comb begin
        for (int i = 0; i < NUM_REGS; i++) begin
            regs_d[i] = regs_q[i];
            if (ext_wr_en && (ext_wr_addr == REG_AW'(i))) regs_d[i] = ext_wr_data;
            if (w_wb_fire && (w_wb_addr == REG_AW'(i))) regs_d[i] = w_wb_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
            state_q   <= c_st_idle;
            result_q  <= '0;
            flags_q   <= '0;
            done_q    <= 1'b0;
            acc_q     <= '0;
            mcand_q   <= '0;
            mplier_q  <= '0;
            cnt_q     <= '0;
            mul_dst_q <= '0;
            mul_wb_q  <= 1'b0;
            mul_fen_q <= 1'b0;
        end else begin
            regs_q    <= regs_d;
            state_q   <= state_d;
            result_q  <= result_d;
            flags_q   <= flags_d;
            done_q    <= done_d;
            acc_q     <= acc_d;
            mcand_q   <= mcand_d;
            mplier_q  <= mplier_d;
            cnt_q     <= cnt_d;
            mul_dst_q <= mul_dst_d;
            mul_wb_q  <= mul_wb_d;
            mul_fen_q <= mul_fen_d;
        end
    end

    assign result = result_q;
    assign flags  = flags_q;
    assign busy   = (state_q == c_st_mul);
    assign done   = done_q;
endmodule
`default_nettype wire

// File: tb/tb_alu_exec_unit.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_alu_exec_unit: scoreboard bench for alu_exec_unit (16-bit and  |
// | 8-bit/12-register instances)                                      |
// | Revision: 1.0                                                     |
// +------------------------------------------------------------------+
module tb_alu_exec_unit;
    localparam logic [3:0] OP_ADD = 4'd0, OP_SUB = 4'd1, OP_AND = 4'd2, OP_OR = 4'd3;
    localparam logic [3:0] OP_XOR = 4'd4, OP_MOV = 4'd5, OP_CMP = 4'd6, OP_LSH = 4'd7;
    localparam logic [3:0] OP_MUL = 4'd8, OP_NOP = 4'd9;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, start, imm_sel, wb_en, flag_en, ext_wr_en;
    logic [3:0]  op, rdst, rsrc, ext_wr_addr;
    logic [15:0] imm, ext_wr_data, rdst_val, rsrc_val, result;
    logic [4:0]  flags;
    logic        busy, done;

    logic        p_start, p_imm_sel, p_wb_en, p_flag_en, p_ext_wr_en;
    logic [3:0]  p_op, p_rdst, p_rsrc, p_ext_wr_addr;
    logic [7:0]  p_imm, p_ext_wr_data, p_rdst_val, p_rsrc_val, p_result;
    logic [4:0]  p_flags;
    logic        p_busy, p_done;

    alu_exec_unit dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .rdst(rdst), .rsrc(rsrc),
        .imm(imm), .imm_sel(imm_sel), .wb_en(wb_en), .flag_en(flag_en),
        .ext_wr_en(ext_wr_en), .ext_wr_addr(ext_wr_addr), .ext_wr_data(ext_wr_data),
        .rdst_val(rdst_val), .rsrc_val(rsrc_val), .result(result), .flags(flags),
        .busy(busy), .done(done)
    );

    alu_exec_unit #(.WIDTH(8), .NUM_REGS(12), .REG_AW(4)) dut8 (
        .clk(clk), .reset(reset), .start(p_start), .op(p_op), .rdst(p_rdst), .rsrc(p_rsrc),
        .imm(p_imm), .imm_sel(p_imm_sel), .wb_en(p_wb_en), .flag_en(p_flag_en),
        .ext_wr_en(p_ext_wr_en), .ext_wr_addr(p_ext_wr_addr), .ext_wr_data(p_ext_wr_data),
        .rdst_val(p_rdst_val), .rsrc_val(p_rsrc_val), .result(p_result), .flags(p_flags),
        .busy(p_busy), .done(p_done)
    );

    typedef struct packed {
        logic [15:0] res;
        logic [4:0]  flg;
    } exp_t;

    exp_t        sbq[$];
    int          total = 0;
    int          bad = 0;
    int          lat;
    logic [15:0] obs_res;
    logic [4:0]  obs_flg;
    logic        done_after;

    task automatic push(input logic [15:0] r, input logic [4:0] f);
        exp_t e;
        e.res = r;
        e.flg = f;
        sbq.push_back(e);
    endtask

    task automatic ext_wr(input logic [3:0] a, input logic [15:0] d);
        @(negedge clk);
        ext_wr_en = 1'b1; ext_wr_addr = a; ext_wr_data = d;
        @(negedge clk);
        ext_wr_en = 1'b0;
    endtask

    task automatic read_reg(input logic [3:0] a, output logic [15:0] v);
        rdst = a;
        #1 v = rdst_val;
    endtask

    // Issues one op and waits (bounded) for done; records latency and outputs.
    task automatic run_op(input logic [3:0] o, input logic [3:0] d, input logic [3:0] s,
                          input logic [15:0] im, input logic isel, input logic wb, input logic fe);
        @(negedge clk);
        op = o; rdst = d; rsrc = s; imm = im; imm_sel = isel; wb_en = wb; flag_en = fe;
        start = 1'b1;
        lat = 0;
        do begin
            @(negedge clk);
            start = 1'b0;
            lat++;
        end while (!done && lat < 40);
        if (!done) lat = -1;
        obs_res = result;
        obs_flg = flags;
        @(negedge clk);
        done_after = done;
    endtask

    task automatic test_reset();
        exp_t e;
        logic [15:0] v;
        int nz;
        ext_wr(4'd3, 16'h1234);
        read_reg(4'd3, v);
        total++; if (v !== 16'h1234) begin bad++; $display("FAIL preload_r3 got=%h want=1234", v); end
        push(16'h0000, 5'b01000);
        run_op(OP_SUB, 4'd3, 4'd0, 16'h1234, 1'b1, 1'b0, 1'b1);
        e = sbq.pop_front();
        total++; if (lat !== 1 || obs_res !== e.res || obs_flg !== e.flg) begin
            bad++; $display("FAIL pre_reset_sub got lat=%0d res=%h flg=%b want lat=1 res=%h flg=%b",
                            lat, obs_res, obs_flg, e.res, e.flg);
        end
        @(negedge clk) reset = 1'b0;
        @(negedge clk) reset = 1'b1;
        nz = 0;
        for (int i = 0; i < 16; i++) begin
            read_reg(i[3:0], v);
            if (v !== 16'h0) nz++;
        end
        total++; if (nz != 0) begin bad++; $display("FAIL reset_regs got nonzero=%0d want 0", nz); end
        total++; if (flags !== 5'b0 || result !== 16'h0) begin
            bad++; $display("FAIL reset_outputs got flg=%b res=%h want 0", flags, result);
        end
        total++; if (busy !== 1'b0 || done !== 1'b0) begin
            bad++; $display("FAIL reset_handshake got busy=%b done=%b want 0", busy, done);
        end
    endtask

    task automatic test_add_sub();
        exp_t e;
        logic [15:0] v;
        ext_wr(4'd1, 16'h7FFF);
        push(16'h8000, 5'b10100);
        run_op(OP_ADD, 4'd1, 4'd0, 16'h0001, 1'b1, 1'b1, 1'b1);
        e = sbq.pop_front();
        total++; if (obs_res !== e.res || obs_flg !== e.flg) begin
            bad++; $display("FAIL add got res=%h flg=%b want res=%h flg=%b", obs_res, obs_flg, e.res, e.flg);
        end
        total++; if (lat !== 1 || done_after !== 1'b0) begin
            bad++; $display("FAIL add_done got lat=%0d done_next=%b want lat=1 done_next=0", lat, done_after);
        end
        read_reg(4'd1, v);
        total++; if (v !== 16'h8000) begin bad++; $display("FAIL add_wb got=%h want=8000", v); end
        ext_wr(4'd2, 16'h0003);
        ext_wr(4'd1, 16'h0005);
        push(16'hFFFE, 5'b10001);
        run_op(OP_SUB, 4'd2, 4'd1, 16'h0000, 1'b0, 1'b1, 1'b1);
        e = sbq.pop_front();
        total++; if (lat !== 1 || obs_res !== e.res || obs_flg !== e.flg) begin
            bad++; $display("FAIL sub got lat=%0d res=%h flg=%b want res=%h flg=%b", lat, obs_res, obs_flg, e.res, e.flg);
        end
        read_reg(4'd2, v);
        total++; if (v !== 16'hFFFE) begin bad++; $display("FAIL sub_wb got=%h want=fffe", v); end
    endtask

    task automatic test_logic();
        exp_t e;
        logic [15:0] v;
        ext_wr(4'd11, 16'hF0F0);
        push(16'h00F0, 5'b00000);
        push(16'hFFF0, 5'b10000);
        push(16'h0000, 5'b01000);
        push(16'h0000, 5'b01000);
        run_op(OP_AND, 4'd11, 4'd0, 16'h0FF0, 1'b1, 1'b1, 1'b1);
        e = sbq.pop_front();
        total++; if (obs_res !== e.res || obs_flg !== e.flg) begin
            bad++; $display("FAIL and got res=%h flg=%b want res=%h flg=%b", obs_res, obs_flg, e.res, e.flg);
        end
        run_op(OP_OR, 4'd11, 4'd0, 16'hFF00, 1'b1, 1'b1, 1'b1);
        e = sbq.pop_front();
        total++; if (obs_res !== e.res || obs_flg !== e.flg) begin
            bad++; $display("FAIL or got res=%h flg=%b want res=%h flg=%b", obs_res, obs_flg, e.res, e.flg);
        end
        run_op(OP_XOR, 4'd11, 4'd0, 16'hFFF0, 1'b1, 1'b1, 1'b1);
        e = sbq.pop_front();
        total++; if (obs_res !== e.res || obs_flg !== e.flg) begin
            bad++; $display("FAIL xor got res=%h flg=%b want res=%h flg=%b", obs_res, obs_flg, e.res, e.flg);
        end
        run_op(OP_NOP, 4'd1, 4'd0, 16'h1234, 1'b1, 1'b1, 1'b1);
        e = sbq.pop_front();
        total++; if (lat !== 1 || obs_res !== e.res || obs_flg !== e.flg) begin
            bad++; $display("FAIL nop got lat=%0d res=%h flg=%b want lat=1 res=%h flg=%b", lat, obs_res, obs_flg, e.res, e.flg);
        end
        read_reg(4'd1, v);
        total++; if (v !== 16'h0005) begin bad++; $display("FAIL nop_no_wb got=%h want=0005", v); end
    endtask

    task automatic test_cmp_mov();
        exp_t e;
        logic [15:0] v;
        ext_wr(4'd4, 16'h0002);
        ext_wr(4'd5, 16'hFFFF);
        push(16'hFFFD, 5'b10000);
        push(16'h0003, 5'b00010);
        push(16'h0000, 5'b00010);
        run_op(OP_CMP, 4'd5, 4'd0, 16'h0002, 1'b1, 1'b1, 1'b1);
        e = sbq.pop_front();
        total++; if (obs_res !== e.res || obs_flg !== e.flg) begin
            bad++; $display("FAIL cmp_signed got res=%h flg=%b want res=%h flg=%b", obs_res, obs_flg, e.res, e.flg);
        end
        run_op(OP_CMP, 4'd4, 4'd5, 16'h0000, 1'b0, 1'b1, 1'b1);
        e = sbq.pop_front();
        total++; if (obs_res !== e.res || obs_flg !== e.flg) begin
            bad++; $display("FAIL cmp_unsigned got res=%h flg=%b want res=%h flg=%b", obs_res, obs_flg, e.res, e.flg);
        end
        read_reg(4'd4, v);
        total++; if (v !== 16'h0002) begin bad++; $display("FAIL cmp_no_wb got=%h want=0002", v); end
        run_op(OP_MOV, 4'd4, 4'd0, 16'h0000, 1'b1, 1'b1, 1'b1);
        e = sbq.pop_front();
        total++; if (obs_res !== e.res || obs_flg !== e.flg) begin
            bad++; $display("FAIL mov got res=%h flg=%b want res=%h flg=%b", obs_res, obs_flg, e.res, e.flg);
        end
        read_reg(4'd4, v);
        total++; if (v !== 16'h0000) begin bad++; $display("FAIL mov_wb got=%h want=0000", v); end
    endtask

    task automatic test_lsh();
        exp_t e;
        logic [15:0] v;
        logic [15:0] init_v [6] = '{16'h00F0, 16'h00F0, 16'h00F0, 16'h0001, 16'hFFFF, 16'hFFFF};
        logic [15:0] amt_v  [6] = '{16'h0004, 16'hFFFC, 16'h0010, 16'h000F, 16'hFFF1, 16'hFFF0};
        logic [15:0] res_v  [6] = '{16'h0F00, 16'h000F, 16'h0000, 16'h8000, 16'h0001, 16'h0000};
        logic [4:0]  flg_v  [6] = '{5'b00000, 5'b00000, 5'b01000, 5'b10000, 5'b00000, 5'b01000};
        for (int k = 0; k < 6; k++) begin
            ext_wr(4'd6, init_v[k]);
            push(res_v[k], flg_v[k]);
            run_op(OP_LSH, 4'd6, 4'd0, amt_v[k], 1'b1, 1'b1, 1'b1);
            e = sbq.pop_front();
            read_reg(4'd6, v);
            total++; if (obs_res !== e.res || obs_flg !== e.flg || v !== e.res) begin
                bad++; $display("FAIL lsh_%0d got res=%h flg=%b reg=%h want res=%h flg=%b", k, obs_res, obs_flg, v, e.res, e.flg);
            end
        end
    endtask

    task automatic test_mul();
        exp_t e;
        logic [15:0] v, mid_r7, b_res;
        logic [4:0]  b_flg;
        logic        b_done;
        int busy_err, done_cyc, done_cnt;
        ext_wr(4'd7, 16'd300);
        push(16'h5F90, 5'b00001);
        push(16'h0007, 5'b00000);
        @(negedge clk);
        op = OP_MUL; rdst = 4'd7; rsrc = 4'd0; imm = 16'd300; imm_sel = 1'b1;
        wb_en = 1'b1; flag_en = 1'b1; start = 1'b1;
        busy_err = 0; done_cyc = -1; done_cnt = 0; mid_r7 = 16'h0;
        b_done = 1'b0; b_res = 16'h0; b_flg = 5'h0;
        for (int c = 1; c <= 24; c++) begin
            @(negedge clk);
            start = 1'b0;
            ext_wr_en = 1'b0;
            if (c == 3) begin
                ext_wr_en = 1'b1; ext_wr_addr = 4'd7; ext_wr_data = 16'h1111;
                rdst = 4'd2; imm = 16'h0002;
            end
            if (c == 4) begin
                rdst = 4'd7;
                #1 mid_r7 = rdst_val;
            end
            if (c == 5) begin
                start = 1'b1; op = OP_ADD; rdst = 4'd8; imm = 16'h0055; wb_en = 1'b1;
            end
            if (busy !== (c <= 15)) busy_err++;
            if (done) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = c;
            end
            if (c == 16 && done) begin
                obs_res = result; obs_flg = flags;
                start = 1'b1; op = OP_ADD; rdst = 4'd9; imm = 16'h0007; imm_sel = 1'b1;
                wb_en = 1'b1; flag_en = 1'b1;
            end
            if (c == 17) begin
                b_done = done; b_res = result; b_flg = flags;
            end
        end
        total++; if (done_cyc != 16) begin bad++; $display("FAIL mul_done_cycle got=%0d want=16", done_cyc); end
        total++; if (busy_err != 0) begin bad++; $display("FAIL mul_busy_window got bad_cycles=%0d want 0", busy_err); end
        e = sbq.pop_front();
        total++; if (obs_res !== e.res || obs_flg !== e.flg) begin
            bad++; $display("FAIL mul got res=%h flg=%b want res=%h flg=%b", obs_res, obs_flg, e.res, e.flg);
        end
        e = sbq.pop_front();
        total++; if (b_done !== 1'b1 || b_res !== e.res || b_flg !== e.flg) begin
            bad++; $display("FAIL back_to_back got done=%b res=%h flg=%b want done=1 res=%h flg=%b", b_done, b_res, b_flg, e.res, e.flg);
        end
        total++; if (done_cnt != 2) begin bad++; $display("FAIL done_pulses got=%0d want=2", done_cnt); end
        total++; if (mid_r7 !== 16'h1111) begin bad++; $display("FAIL ext_wr_during_mul got=%h want=1111", mid_r7); end
        read_reg(4'd7, v);
        total++; if (v !== 16'h5F90) begin bad++; $display("FAIL mul_wb got=%h want=5f90", v); end
        read_reg(4'd8, v);
        total++; if (v !== 16'h0000) begin bad++; $display("FAIL busy_start_ignored got r8=%h want=0000", v); end
        read_reg(4'd9, v);
        total++; if (v !== 16'h0007) begin bad++; $display("FAIL back_to_back_wb got=%h want=0007", v); end
    endtask

    task automatic test_reset_mid_mul();
        exp_t e;
        logic [15:0] v;
        int dn;
        logic bsy;
        ext_wr(4'd10, 16'd3);
        @(negedge clk);
        op = OP_MUL; rdst = 4'd10; imm = 16'd5; imm_sel = 1'b1; wb_en = 1'b1; flag_en = 1'b1; start = 1'b1;
        dn = 0; bsy = 1'b1;
        for (int c = 1; c <= 24; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (c == 8) reset = 1'b0;
            if (c == 9) reset = 1'b1;
            if (done) dn++;
            if (c == 20) bsy = busy;
        end
        read_reg(4'd10, v);
        total++; if (dn != 0 || bsy !== 1'b0) begin
            bad++; $display("FAIL reset_mid_mul got done_pulses=%0d busy=%b want 0/0", dn, bsy);
        end
        total++; if (v !== 16'h0 || result !== 16'h0 || flags !== 5'b0) begin
            bad++; $display("FAIL reset_mid_mul_state got r10=%h res=%h flg=%b want 0", v, result, flags);
        end
        push(16'h0001, 5'b00000);
        run_op(OP_ADD, 4'd10, 4'd0, 16'h0001, 1'b1, 1'b1, 1'b1);
        e = sbq.pop_front();
        total++; if (lat !== 1 || obs_res !== e.res || obs_flg !== e.flg) begin
            bad++; $display("FAIL idle_after_reset got lat=%0d res=%h flg=%b want lat=1 res=%h flg=%b", lat, obs_res, obs_flg, e.res, e.flg);
        end
    endtask

    task automatic test_param();
        exp_t e;
        int plat;
        logic [7:0] v0, v13, v1, v11;
        logic [7:0] addr_v [4] = '{8'd0, 8'd13, 8'd11, 8'd12};
        logic [7:0] data_v [4] = '{8'd15, 8'hAA, 8'h5A, 8'h77};
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            p_ext_wr_en = 1'b1; p_ext_wr_addr = addr_v[k][3:0]; p_ext_wr_data = data_v[k];
        end
        @(negedge clk);
        p_ext_wr_en = 1'b0;
        push(16'h00FF, 5'b10000);
        @(negedge clk);
        p_op = OP_MUL; p_rdst = 4'd0; p_imm = 8'd17; p_imm_sel = 1'b1;
        p_wb_en = 1'b1; p_flag_en = 1'b1; p_start = 1'b1;
        plat = -1;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            p_start = 1'b0;
            if (p_done && plat < 0) begin
                plat = c; obs_res = {8'h00, p_result}; obs_flg = p_flags;
            end
        end
        e = sbq.pop_front();
        total++; if (plat != 8) begin bad++; $display("FAIL w8_mul_done_cycle got=%0d want=8", plat); end
        total++; if (obs_res !== e.res || obs_flg !== e.flg) begin
            bad++; $display("FAIL w8_mul got res=%h flg=%b want res=%h flg=%b", obs_res, obs_flg, e.res, e.flg);
        end
        p_rdst = 4'd0; p_rsrc = 4'd11;
        #1 v0 = p_rdst_val; v11 = p_rsrc_val;
        p_rdst = 4'd13; p_rsrc = 4'd1;
        #1 v13 = p_rdst_val; v1 = p_rsrc_val;
        total++; if (v0 !== 8'hFF) begin bad++; $display("FAIL w8_mul_wb got=%h want=ff", v0); end
        total++; if (v11 !== 8'h5A) begin bad++; $display("FAIL w8_last_reg got=%h want=5a", v11); end
        total++; if (v13 !== 8'h00 || v1 !== 8'h00) begin
            bad++; $display("FAIL w8_out_of_range got r13=%h r1=%h want 00/00", v13, v1);
        end
        total++; if (p_busy !== 1'b0) begin bad++; $display("FAIL w8_idle_busy got=%b want=0", p_busy); end
    endtask

    initial begin
        reset = 1'b0; start = 1'b0; op = 4'd0; rdst = 4'd0; rsrc = 4'd0; imm = 16'h0;
        imm_sel = 1'b0; wb_en = 1'b0; flag_en = 1'b0;
        ext_wr_en = 1'b0; ext_wr_addr = 4'd0; ext_wr_data = 16'h0;
        p_start = 1'b0; p_op = 4'd0; p_rdst = 4'd0; p_rsrc = 4'd0; p_imm = 8'h0;
        p_imm_sel = 1'b0; p_wb_en = 1'b0; p_flag_en = 1'b0;
        p_ext_wr_en = 1'b0; p_ext_wr_addr = 4'd0; p_ext_wr_data = 8'h0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        test_reset();
        test_add_sub();
        test_logic();
        test_cmp_mov();
        test_lsh();
        test_mul();
        test_reset_mid_mul();
        test_param();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
